// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered, held grants and an optional hold limit.
// The priority pointer rotates below each departing owner, so no requester starves.
module rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        OWNED
    } mode_t;

    mode_t            mode, mode_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] ptr, ptr_n, ptr_rot;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [N-1:0]     gnt_n;
    logic [IDX_W-1:0] idx_n;
    logic             valid_n;
    logic [IDX_W:0]   pick_cur, pick_rot;
    logic             hold_ok;

    // Returns {found, index} of the first set bit scanning p, p-1, ..., 0, N-1, ..., p+1.
    function automatic logic [IDX_W:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
        logic             found;
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] k;
        found = 1'b0;
        w     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = IDX_W'((32'(p) + N - i) % N);
            if (!found && r[k]) begin
                found = 1'b1;
                w     = k;
            end
        end
        return {found, w};
    endfunction

    always_comb begin
        ptr_rot  = (owner == '0) ? IDX_W'(N - 1) : owner - 1'b1;
        pick_cur = pick(req, ptr);
        pick_rot = pick(req, ptr_rot);
        hold_ok  = (MAX_HOLD == 0) || (cnt < CNT_W'(MAX_HOLD));

        mode_n  = mode;
        owner_n = owner;
        cnt_n   = cnt;
        ptr_n   = ptr;

        if (!en) begin
            mode_n = IDLE;
            if (mode == OWNED) ptr_n = ptr_rot;
        end else if (mode == IDLE) begin
            if (pick_cur[IDX_W]) begin
                owner_n = pick_cur[IDX_W-1:0];
                cnt_n   = CNT_W'(1);
                mode_n  = OWNED;
            end
        end else if (req[owner] && hold_ok) begin
            if (cnt != '1) cnt_n = cnt + 1'b1;
        end else begin
            // Hand-off re-arbitrates on the same edge with the departing owner now lowest priority.
            ptr_n = ptr_rot;
            if (pick_rot[IDX_W]) begin
                owner_n = pick_rot[IDX_W-1:0];
                cnt_n   = CNT_W'(1);
            end else begin
                mode_n = IDLE;
            end
        end

        gnt_n   = '0;
        idx_n   = '0;
        valid_n = 1'b0;
        if (mode_n == OWNED) begin
            gnt_n[owner_n] = 1'b1;
            idx_n          = owner_n;
            valid_n        = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode      <= IDLE;
            owner     <= '0;
            cnt       <= '0;
            ptr       <= IDX_W'(N - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            mode      <= mode_n;
            owner     <= owner_n;
            cnt       <= cnt_n;
            ptr       <= ptr_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Randomized and directed bench for rr_arbiter against a behavioural model,
// covering the (8,4), (8,0) and (5,4) builds driven by shared stimulus.
module tb_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en;
    logic [7:0] req;
    logic [7:0] gnt8, gnt8u;
    logic [4:0] gnt5;
    logic [2:0] idx8, idx8u, idx5;
    logic       v8, v8u, v5;

    rr_arbiter #(.N(8), .MAX_HOLD(4)) d8 (
        .clock(clk), .reset(rst), .en(en), .req(req),
        .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(v8)
    );
    rr_arbiter #(.N(8), .MAX_HOLD(0)) d8u (
        .clock(clk), .reset(rst), .en(en), .req(req),
        .gnt(gnt8u), .gnt_idx(idx8u), .gnt_valid(v8u)
    );
    rr_arbiter #(.N(5), .MAX_HOLD(4)) d5 (
        .clock(clk), .reset(rst), .en(en), .req(req[4:0]),
        .gnt(gnt5), .gnt_idx(idx5), .gnt_valid(v5)
    );

    int checks = 0;
    int errors = 0;

    // owner = -1 means nobody holds the grant
    typedef struct packed {
        int owner;
        int cnt;
        int ptr;
    } st_t;

    st_t m8, m8u, m5;
    int  waits[8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input logic [31:0] r, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (p - k + n) % n;
            if (((r >> i) & 32'd1) != 0) return i;
        end
        return -1;
    endfunction

    function automatic st_t step(input st_t s, input int n, input int mh,
                                 input logic r, input logic e, input logic [31:0] q);
        st_t t;
        int  w;
        t = s;
        if (r) begin
            t.owner = -1; t.cnt = 0; t.ptr = n - 1;
        end else if (!e) begin
            if (s.owner >= 0) t.ptr = (s.owner + n - 1) % n;
            t.owner = -1;
        end else if (s.owner < 0) begin
            w = winner(q, s.ptr, n);
            if (w >= 0) begin t.owner = w; t.cnt = 1; end
        end else if ((((q >> s.owner) & 32'd1) != 0) && (mh == 0 || s.cnt < mh)) begin
            t.cnt = s.cnt + 1;
        end else begin
            t.ptr   = (s.owner + n - 1) % n;
            w       = winner(q, t.ptr, n);
            t.owner = w;
            t.cnt   = (w >= 0) ? 1 : 0;
        end
        return t;
    endfunction

    function automatic logic [31:0] egnt(input st_t s);
        return (s.owner >= 0) ? (32'd1 << s.owner) : 32'd0;
    endfunction

    function automatic logic [31:0] eidx(input st_t s);
        return (s.owner >= 0) ? 32'(s.owner) : 32'd0;
    endfunction

    function automatic logic [31:0] evld(input st_t s);
        return (s.owner >= 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic [7:0] q);
        int worst;
        rst = r; en = e; req = q;
        @(posedge clk);
        m8  = step(m8,  8, 4, r, e, {24'b0, q});
        m8u = step(m8u, 8, 0, r, e, {24'b0, q});
        m5  = step(m5,  5, 4, r, e, {27'b0, q[4:0]});
        #1;
        check("d8.gnt",  {24'b0, gnt8},  egnt(m8));
        check("d8.idx",  {29'b0, idx8},  eidx(m8));
        check("d8.vld",  {31'b0, v8},    evld(m8));
        check("d8u.gnt", {24'b0, gnt8u}, egnt(m8u));
        check("d8u.idx", {29'b0, idx8u}, eidx(m8u));
        check("d8u.vld", {31'b0, v8u},   evld(m8u));
        check("d5.gnt",  {27'b0, gnt5},  egnt(m5));
        check("d5.idx",  {29'b0, idx5},  eidx(m5));
        check("d5.vld",  {31'b0, v5},    evld(m5));
        check("d8.onehot", {31'b0, $onehot0(gnt8)}, 32'd1);
        worst = 0;
        for (int i = 0; i < 8; i++) begin
            if (r || !e) waits[i] = 0;
            else if (q[i] && !gnt8[i]) waits[i]++;
            else waits[i] = 0;
            if (waits[i] > worst) worst = waits[i];
        end
        check("d8.starve", {31'b0, worst > 29}, 32'd0);
    endtask

    logic [7:0] q;
    logic [7:0] seq_exp;

    initial begin
        rst = 1'b1; en = 1'b1; req = '0;
        for (int i = 0; i < 8; i++) waits[i] = 0;
        m8 = '0; m8u = '0; m5 = '0;

        // reset dominates a full request vector
        cyc(1'b1, 1'b1, 8'hFF);
        cyc(1'b1, 1'b1, 8'hFF);
        check("rst.gnt", {24'b0, gnt8}, 32'h0);
        check("rst.idx", {29'b0, idx8}, 32'h0);
        check("rst.vld", {31'b0, v8}, 32'h0);
        cyc(1'b0, 1'b1, 8'hFF);
        check("first.gnt", {24'b0, gnt8}, 32'h80);
        check("first.idx", {29'b0, idx8}, 32'h7);

        // hold-limit rotation 7 -> 6 -> 4 -> 7 with no bubble
        cyc(1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 13; k++) begin
            cyc(1'b0, 1'b1, 8'hD0);
            seq_exp = (k < 4) ? 8'h80 : (k < 8) ? 8'h40 : (k < 12) ? 8'h10 : 8'h80;
            check("rot.gnt", {24'b0, gnt8}, {24'b0, seq_exp});
        end

        // owner 0 releases: pointer wraps to 7, requester 1 wins
        cyc(1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b1, 8'h03);
        check("wrap.own0", {24'b0, gnt8}, 32'h01);
        cyc(1'b0, 1'b1, 8'h02);
        check("wrap.gnt", {24'b0, gnt8}, 32'h02);

        // lone requester re-granted at the hold limit without a gap
        cyc(1'b1, 1'b1, 8'h00);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b1, 8'h04);
            check("lone.gnt", {24'b0, gnt8}, 32'h04);
            check("lone.vld", {31'b0, v8}, 32'h1);
        end

        // enable drop with owner 5, resume from pointer 4
        cyc(1'b1, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h22);
        check("en.own5", {24'b0, gnt8}, 32'h20);
        cyc(1'b0, 1'b0, 8'h22);
        check("en.off", {24'b0, gnt8}, 32'h00);
        cyc(1'b0, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 8'h22);
        check("en.resume", {24'b0, gnt8}, 32'h02);

        // random traffic; mostly sticky requests so hold limits are exercised
        q = 8'($urandom);
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 3) == 0) q = 8'($urandom);
            else if ($urandom_range(0, 1) == 0) q = q ^ (8'd1 << $urandom_range(0, 7));
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), q);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Parametrised N-way round-robin arbiter with registered, held grants. It is the sequential successor to the fixed-priority 8-bit selector. Fixed index priority is replaced by a rotating priority pointer, so no requester starves. A grant is held across multi-cycle bursts, and an optional hold limit forces hand-off. The block sits wherever several pipeline clients share one resource port (e.g. memory or CDB access).

## Interface
- N, default 8, number of requesters (legal 2..32); IDX_W = $clog2(N) is derived internally.
- MAX_HOLD, default 4, maximum consecutive cycles one owner keeps the grant; 0 = unlimited.
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; low forces grant release.
- req  input  N  request vector, bit i = requester i.
- gnt  output  N  registered grant, one-hot or all-zero.
- gnt_idx  output  IDX_W  binary index of the granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high iff gnt is non-zero.

## Operation
- State:
  - mode IDLE/OWNED.
  - owner index o.
  - hold counter cnt, sized to hold MAX_HOLD.
  - priority pointer ptr = index of the current highest-priority requester.
- Winner search: scan indices ptr, ptr-1, …, 0, N-1, …, ptr+1 (descending with wrap). The first asserted req bit wins.
- Reset: mode=IDLE, ptr=N-1, cnt=0, gnt=0, gnt_idx=0, gnt_valid=0. With ptr=N-1, the first arbitration after reset matches plain MSB-first priority.
- Every posedge, in priority order:
  1. reset: apply reset values. Reset wins over every other input, including mid-ownership.
  2. en=0: gnt←0 and mode←IDLE. If OWNED, ptr←(o-1) mod N; otherwise ptr is unchanged.
  3. IDLE:
     - If req=0, gnt stays 0.
     - Otherwise winner w: gnt←onehot(w), o←w, cnt←1, mode←OWNED.
  4. OWNED, continue: req[o]=1 and (MAX_HOLD=0 or cnt<MAX_HOLD). gnt is unchanged and cnt←cnt+1 (saturating when MAX_HOLD=0).
  5. OWNED, hand-off: req[o]=0, or cnt reached MAX_HOLD.
     - ptr←(o-1) mod N. Owner 0 wraps ptr to N-1.
     - Re-arbitrate in the same edge using the new ptr, so o is now lowest priority.
     - If a winner exists: grant it, cnt←1, stay OWNED. No idle bubble.
     - If req=0: gnt←0 and mode←IDLE.
     - At hold limit, if o is the only requester it is re-granted with cnt←1. gnt does not glitch.
- Invariants: gnt is always one-hot or zero; gnt_idx and gnt_valid always agree with gnt.
- Bits of req outside the current owner never pre-empt an active ownership before hand-off.

## Timing
- All outputs are registered. There is no combinational path from req or en to any output.
- Grant latency: 1 cycle. A req sampled at edge t is reflected on gnt after edge t.
- Release latency: an owner dropping req before edge t loses gnt after edge t. The owner therefore sees gnt for exactly one cycle with its own req low. Clients must tolerate this.
- Hold limit: with continuous request and competition, an owner holds gnt for exactly MAX_HOLD cycles. The next owner's gnt appears on the same edge the old one drops.
- en low: gnt is zero 1 cycle later. With en low, requests are ignored. When en returns high, arbitration resumes from IDLE with the rotated ptr.
- Simultaneous events:
  - Owner release and new request on the same edge give an immediate hand-off.
  - Reset together with en or req gives reset values.

## Test plan
All scenarios use N=8, MAX_HOLD=4 unless stated.
- Reset with req=8'b11111111, en=1 → gnt=0, gnt_idx=0, gnt_valid=0 while reset is high. Cycle after reset falls: gnt=8'b10000000, gnt_idx=7.
- After reset, req=8'b11010000 held → gnt=10000000 for 4 cycles, then 01000000 for 4, then 00010000 for 4, then 10000000. Never zero between.
- Wrap: owner 0 (req=8'b00000011, ptr forced by prior grants so 0 wins) drops bit 0 → ptr=7, next gnt=00000010.
- Lone requester req=8'b00000100 held 10 cycles → gnt=00000100 every cycle after the first; gnt_valid is never low.
- en drop: owner 5 granted, en=0 for 2 cycles with req=8'b00100010 → gnt=0 one cycle after en falls. After en rises, gnt=00000010 (ptr=4).
- Invariant check over 2000 random cycles of req/en/reset, plus MAX_HOLD=0 and N=5 builds → gnt one-hot-or-zero, gnt_idx consistent, no requester waits more than (N-1)×MAX_HOLD+1 cycles while continuously requesting.
